cfi_log_queue: RTL

//  Buffers control-flow records (cfi_pkg::cfi_log_t) produced at commit and feeds them to the
//  CFI stage through a valid/ready handshake. Discards records with no CFI flag set. Raises an

---
 rtl/cfi_log_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cfi_log_queue.sv
// Control-flow log queue between commit and the CFI checking stage.
// Optional saturating drop counter built when CFI_LOG_DROP_CNT_EN is defined.
package cfi_pkg;
    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] addr_pc;
        logic [31:0] addr_npc;
        logic [31:0] addr_target;
    } cfi_log_t;
endpackage

module cfi_log_queue #(
    parameter int DEPTH      = 8,
    parameter int STALL_FREE = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              clr_ovf_i,
    input  logic              log_valid_i,
    input  cfi_pkg::cfi_log_t log_i,
    output logic              stall_o,
    output logic              log_valid_o,
    output cfi_pkg::cfi_log_t log_o,
    input  logic              log_ready_i,
    output logic              overflow_o,
    output logic [15:0]       drop_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_FREE_C = CW'(STALL_FREE);

    cfi_pkg::cfi_log_t mem_q [DEPTH];
    cfi_pkg::cfi_log_t mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_d;
    logic          stall_q, stall_d;
    logic          overflow_q, overflow_d;
    logic          cand, full, empty, pop, push, drop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign cand  = log_valid_i & (|log_i.flags);
    assign pop   = !empty & log_ready_i;
    assign push  = cand & (!full | pop);
    assign drop  = cand & full & !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = log_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Stall is registered from the post-update occupancy so commit sees it one cycle early.
    always_comb begin
        free_d  = DEPTH_C - count_d;
        stall_d = (free_d <= STALL_FREE_C);
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef CFI_LOG_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (clr_ovf_i) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clr_ovf_i) begin
            drop_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = 16'h0;
`endif

    assign log_valid_o = !empty;
    assign log_o       = mem_q[rd_ptr_q];
    assign stall_o     = stall_q;
    assign overflow_o  = overflow_q;
endmodule
